// File: rtl/alu_pkg.sv
// Shared ALU divider definitions: default width, FSM state encoding
// and the fixed divide latency used by the EX-stage stall logic.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } div_state_t;

  localparam int DIV_LATENCY = WIDTH + 2;

endpackage

// File: rtl/alu_div_seq_if.sv
// Divider request/result bundle: start/Sign/A/B in, busy/done/quo/rem/DZ/V out.
// master = EX pipeline side, slave = divider.
interface alu_div_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             Sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             DZ;
  logic             V;

  modport master (
    output start, Sign, A, B,
    input  busy, done, quo, rem, DZ, V
  );

  modport slave (
    input  start, Sign, A, B,
    output busy, done, quo, rem, DZ, V
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the result if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {r_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign r_out   = q_bit ? diff[WIDTH:0]
                         : shifted[WIDTH:0];

endmodule

// File: rtl/alu_div_seq.sv
// Sequential restoring divider (DIV/DIVU), one quotient bit per cycle.
// Ports: clk, reset (sync, active-low), bus (alu_div_seq_if.slave).
module alu_div_seq #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_div_seq_if.slave bus
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  div_state_t state_q;
  div_state_t state_d;

  logic             sgn;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divs;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt;
  logic             qneg;
  logic             rneg;
  logic             dz0;

  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             v_q;

  logic [WIDTH:0]   r_nx;
  logic             q_bit;
  logic             b_zero;
  logic             ovf;

  // dq starts as |A| and fills with quotient bits from the right.
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .divisor (divs),
    .bit_in  (dq[WIDTH-1]),
    .r_out   (r_nx),
    .q_bit   (q_bit)
  );

  assign b_zero = (b_q == '0);
  assign ovf    = sgn
                & (a_q == {1'b1, {(WIDTH-1){1'b0}}})
                & (b_q == '1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = PREP;
      PREP: state_d = b_zero ? FIX : ITER;
      ITER: if (cnt == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sgn     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dq      <= '0;
      divs    <= '0;
      r_q     <= '0;
      cnt     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dz0     <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sgn  <= bus.Sign;
            a_q  <= bus.A;
            b_q  <= bus.B;
            dz_q <= 1'b0;
            v_q  <= 1'b0;
          end
        end
        PREP: begin
          dq   <= (sgn & a_q[WIDTH-1]) ? -a_q : a_q;
          divs <= (sgn & b_q[WIDTH-1]) ? -b_q : b_q;
          r_q  <= '0;
          cnt  <= CW'(WIDTH - 1);
          qneg <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg <= sgn & a_q[WIDTH-1];
          dz0  <= b_zero;
        end
        ITER: begin
          dq  <= {dq[WIDTH-2:0], q_bit};
          r_q <= r_nx;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (dz0) begin
            quo_q <= '1;
            rem_q <= a_q;
            dz_q  <= 1'b1;
            v_q   <= 1'b0;
          end else begin
            quo_q <= qneg ? -dq : dq;
            rem_q <= rneg ? -r_q[WIDTH-1:0]
                          : r_q[WIDTH-1:0];
            dz_q  <= 1'b0;
            v_q   <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // The done cycle is IDLE but still counts as busy for the stall logic.
  assign bus.busy = (state_q != IDLE) | done_q;
  assign bus.done = done_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;
  assign bus.DZ   = dz_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: results, flags, latency,
// busy-ignore, back-to-back issue and reset abort.
module tb_alu_div_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int ncmp = 0;
  int nfail = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  alu_div_seq_if #(.WIDTH(32)) bus ();

  alu_div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic s,
                    input logic [31:0] a,
                    input logic [31:0] b);
    bus.Sign  = s;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Edges counted from the accept edge; bounded at 60.
  task automatic wait_done(output int n, input bit spur);
    n = 0;
    do begin
      step();
      n++;
      if (spur) begin
        bus.start = (n == 5) || (n == 20);
        if (bus.start) begin
          bus.A = 32'd5;
          bus.B = 32'd1;
        end
      end
    end while (!bus.done && n < 60);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.Sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quo", bus.quo, 32'd0);
    check("rst_rem", bus.rem, 32'd0);
    check("rst_dz", 32'(bus.DZ), 32'd0);
    check("rst_v", 32'(bus.V), 32'd0);
    reset = 1'b1;
    step();

    // 100 / 7 unsigned
    go(1'b0, 32'd100, 32'd7);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_done(lat, 1'b0);
    check("t1_lat", lat, 32'd34);
    check("t1_quo", bus.quo, 32'd14);
    check("t1_rem", bus.rem, 32'd2);
    check("t1_dz", 32'(bus.DZ), 32'd0);
    check("t1_v", 32'(bus.V), 32'd0);
    check("t1_busy_done", 32'(bus.busy), 32'd1);
    step();
    check("t1_pulse", 32'(bus.done), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_hold", bus.quo, 32'd14);

    // -7 / 2 signed
    go(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, 1'b0);
    check("t2_lat", lat, 32'd34);
    check("t2_quo", bus.quo, 32'hFFFF_FFFD);
    check("t2_rem", bus.rem, 32'hFFFF_FFFF);
    check("t2_v", 32'(bus.V), 32'd0);
    step();

    // signed overflow
    go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, 1'b0);
    check("t3_lat", lat, 32'd34);
    check("t3_quo", bus.quo, 32'h8000_0000);
    check("t3_rem", bus.rem, 32'd0);
    check("t3_v", 32'(bus.V), 32'd1);
    check("t3_dz", 32'(bus.DZ), 32'd0);
    step();

    // divide by zero: PREP, FIX, then done (third cycle)
    go(1'b1, 32'h0000_1234, 32'd0);
    wait_done(lat, 1'b0);
    check("t4_lat", lat, 32'd2);
    check("t4_dz", 32'(bus.DZ), 32'd1);
    check("t4_v", 32'(bus.V), 32'd0);
    check("t4_quo", bus.quo, 32'hFFFF_FFFF);
    check("t4_rem", bus.rem, 32'h0000_1234);
    step();

    // starts while busy are ignored
    go(1'b0, 32'd1000, 32'd3);
    check("t5_dzclr", 32'(bus.DZ), 32'd0);
    wait_done(lat, 1'b1);
    check("t5_lat", lat, 32'd34);
    check("t5_quo", bus.quo, 32'd333);
    check("t5_rem", bus.rem, 32'd1);

    // back-to-back issue on the done cycle
    go(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat, 1'b0);
    check("t5b_lat", lat, 32'd34);
    check("t5b_quo", bus.quo, 32'hFFFF_FFF2);
    check("t5b_rem", bus.rem, 32'hFFFF_FFFE);
    step();

    // reset mid-iteration aborts
    go(1'b0, 32'd100, 32'd7);
    repeat (11) step();
    reset = 1'b0;
    step();
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_quo", bus.quo, 32'd0);
    check("t6_rem", bus.rem, 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) seen++;
    end
    check("t6_nodone", seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
